// File: rtl/dpram_be_clr.sv
// Dual-port block RAM: port A read-only, port B read/write with byte enables,
// selectable read-during-write on B, and a sequential fill engine for clearing.
module dpram_be_clr #(
   parameter int unsigned addr_width     = 10,
   parameter int unsigned data_width     = 8,
   parameter bit          rdw_new        = 1'b0,
   parameter logic [7:0]  clear_value    = 8'h00,
   parameter bit          clear_on_reset = 1'b1,
   localparam int unsigned lanes         = data_width / 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   output logic                  busy,
   input  logic [addr_width-1:0] addr,
   input  logic                  ce,
   input  logic                  oe,
   output logic [data_width-1:0] dout,
   input  logic                  we,
   input  logic [lanes-1:0]      be,
   input  logic [addr_width-1:0] waddr,
   input  logic [data_width-1:0] wdata,
   output logic [data_width-1:0] doutb
);

   localparam int unsigned depth = 2 ** addr_width;
   localparam logic [addr_width-1:0] last_addr  = addr_width'(depth - 1);
   localparam logic [data_width-1:0] clear_word = {lanes{clear_value}};

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   logic [data_width-1:0] mem [depth];

   state_t                state_q, state_d;
   logic [addr_width-1:0] cnt_q, cnt_d;
   logic                  busy_q, busy_d;
   logic [data_width-1:0] areg_q, areg_d;
   logic [data_width-1:0] doutb_q, doutb_d;

   logic [lanes-1:0]      lane_we_c;
   logic [addr_width-1:0] mem_addr_c;
   logic [data_width-1:0] mem_wdata_c;
   logic [data_width-1:0] rdb_c;
   logic [data_width-1:0] merged_c;

   // Port B old word and the word it becomes after a byte-masked write.
   always_comb begin
      rdb_c    = mem[waddr];
      merged_c = rdb_c;
      for (int unsigned i = 0; i < lanes; i++) begin
         if (we && be[i]) begin
            merged_c[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   // Next-state: clear sequencing, memory write steering and read registers.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      doutb_d     = doutb_q;
      areg_d      = mem[addr];
      lane_we_c   = '0;
      mem_addr_c  = waddr;
      mem_wdata_c = merged_c;

      case (state_q)
         IDLE: begin
            if (we) begin
               lane_we_c = be;
            end
            doutb_d = rdw_new ? merged_c : rdb_c;
            if (clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         CLEAR: begin
            // Fill engine owns the write port; port B writes are dropped.
            lane_we_c   = '1;
            mem_addr_c  = cnt_q;
            mem_wdata_c = clear_word;
            if (cnt_q == last_addr) begin
               state_d = IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + addr_width'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= clear_on_reset ? CLEAR : IDLE;
         busy_q  <= clear_on_reset;
         cnt_q   <= '0;
         areg_q  <= '0;
         doutb_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         areg_q  <= areg_d;
         doutb_q <= doutb_d;
      end
   end

   // Storage array has no reset so it maps onto block RAM with lane write enables.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < lanes; i++) begin
         if (lane_we_c[i]) begin
            mem[mem_addr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
         end
      end
   end

   assign dout  = (~ce & ~oe) ? areg_q : '0;
   assign busy  = busy_q;
   assign doutb = doutb_q;

endmodule
